// File: rtl/mem_trans_stage_if.sv
// Request/translation input bundle and dcache-side output bundle of mem_trans_stage.
// The stage itself uses the slave modport; the producer/consumer side uses master.
interface mem_trans_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_va;
    logic        in_is_store;
    logic [1:0]  in_size;
    logic [31:0] tr_pa;
    logic [1:0]  tr_mat;
    logic        tr_page_fault;
    logic        tr_page_invalid;
    logic        tr_page_dirty;
    logic        tr_plv_fault;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pa;
    logic [31:0] out_va;
    logic [1:0]  out_mat;
    logic        out_is_store;
    logic [1:0]  out_size;
    logic        out_exc;
    logic [5:0]  out_ecode;

    modport master (
        output in_valid, in_va, in_is_store, in_size,
               tr_pa, tr_mat, tr_page_fault, tr_page_invalid, tr_page_dirty, tr_plv_fault,
               out_ready,
        input  in_ready, out_valid, out_pa, out_va, out_mat, out_is_store, out_size,
               out_exc, out_ecode
    );

    modport slave (
        input  in_valid, in_va, in_is_store, in_size,
               tr_pa, tr_mat, tr_page_fault, tr_page_invalid, tr_page_dirty, tr_plv_fault,
               out_ready,
        output in_ready, out_valid, out_pa, out_va, out_mat, out_is_store, out_size,
               out_exc, out_ecode
    );
endinterface

// File: rtl/mem_trans_stage.sv
// Memory translation stage: classifies LoongArch memory exceptions and buffers requests for the dcache.
// Optional alignment (ALE) check is enabled by defining MEM_TRANS_ALE_EN.
module mem_trans_stage #(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    mem_trans_stage_if.slave  bus
);

    localparam logic [5:0] ECODE_NONE = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef enum logic {RUN, HOLD} state_t;

    typedef struct packed {
        logic [31:0] pa;
        logic [31:0] va;
        logic [1:0]  mat;
        logic        isStore;
        logic [1:0]  size;
        logic        exc;
        logic [5:0]  ecode;
    } entry_t;

    state_t      r_state;
    state_t      w_stateNext;
    entry_t      r_mem [DEPTH];
    logic        r_headPtr;
    logic        r_tailPtr;
    logic [1:0]  r_count;

    logic        w_misaligned;
    logic        w_exc;
    logic [5:0]  w_ecode;
    logic        w_push;
    logic        w_pop;
    entry_t      w_newEntry;
    entry_t      w_head;

    function automatic logic nextPtr(input logic p);
        return (DEPTH == 1) ? 1'b0 : ~p;
    endfunction

`ifdef MEM_TRANS_ALE_EN
    // Size 3 is treated as a word access for alignment purposes.
    assign w_misaligned = ((bus.in_size == 2'd1) && bus.in_va[0]) ||
                          (bus.in_size[1] && (bus.in_va[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_exc   = 1'b1;
        w_ecode = ECODE_NONE;
        if (w_misaligned) begin
            w_ecode = ECODE_ALE;
        end else if (bus.tr_page_fault) begin
            w_ecode = ECODE_TLBR;
        end else if (bus.tr_page_invalid) begin
            w_ecode = bus.in_is_store ? ECODE_PIS : ECODE_PIL;
        end else if (bus.tr_plv_fault) begin
            w_ecode = ECODE_PPI;
        end else if (bus.in_is_store && bus.tr_page_dirty) begin
            w_ecode = ECODE_PME;
        end else begin
            w_exc   = 1'b0;
        end
    end

    generate
        if (DEPTH == 1) begin : g_readyDepth1
            assign bus.in_ready = (r_state == RUN) && ((r_count == 2'd0) || bus.out_ready);
        end else begin : g_readyDepth2
            assign bus.in_ready = (r_state == RUN) && (r_count < 2'd2);
        end
    endgenerate

    assign w_push = bus.in_valid && bus.in_ready && !flush;
    assign w_pop  = bus.out_valid && bus.out_ready && !flush;

    assign w_newEntry = '{pa: bus.tr_pa, va: bus.in_va, mat: bus.tr_mat,
                          isStore: bus.in_is_store, size: bus.in_size,
                          exc: w_exc, ecode: w_ecode};

    // Entry storage is cleared only on reset so the outputs return to zero then.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_headPtr <= 1'b0;
            r_tailPtr <= 1'b0;
            r_count   <= 2'd0;
        end else if (flush) begin
            r_headPtr <= 1'b0;
            r_tailPtr <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tailPtr] <= w_newEntry;
                r_tailPtr        <= nextPtr(r_tailPtr);
            end
            if (w_pop) begin
                r_headPtr <= nextPtr(r_headPtr);
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (flush) begin
            w_stateNext = RUN;
        end else begin
            case (r_state)
                RUN:     if (w_push && w_exc) w_stateNext = HOLD;
                HOLD:    w_stateNext = HOLD;
                default: w_stateNext = RUN;
            endcase
        end
    end

    assign w_head           = r_mem[r_headPtr];
    assign bus.out_valid    = (r_count != 2'd0);
    assign bus.out_pa       = w_head.pa;
    assign bus.out_va       = w_head.va;
    assign bus.out_mat      = w_head.mat;
    assign bus.out_is_store = w_head.isStore;
    assign bus.out_size     = w_head.size;
    assign bus.out_exc      = w_head.exc;
    assign bus.out_ecode    = w_head.exc ? w_head.ecode : ECODE_NONE;

endmodule

// File: tb/tb_mem_trans_stage.sv
// Directed plus short random test of mem_trans_stage (DEPTH = 2) against a scoreboard model.
module tb_mem_trans_stage;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    mem_trans_stage_if bus();

    mem_trans_stage #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] pa;
        logic [31:0] va;
        logic [1:0]  mat;
        logic        isStore;
        logic [1:0]  size;
        logic        exc;
        logic [5:0]  ecode;
    } exp_t;

    exp_t sb[$];
    bit   modelHold;
    int   total;
    int   bad;

    function automatic logic [5:0] refEcode(input logic [31:0] va, input logic st,
                                            input logic [1:0] size, input logic pf,
                                            input logic pi, input logic pd, input logic plv);
`ifdef MEM_TRANS_ALE_EN
        if (((size == 2'd1) && va[0]) || ((size >= 2'd2) && (va[1:0] != 2'b00))) return 6'h09;
`endif
        if (pf) return 6'h3F;
        if (pi) return st ? 6'h02 : 6'h01;
        if (plv) return 6'h07;
        if (st && pd) return 6'h04;
        return 6'h00;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares DUT outputs with the model, then advances the model for the coming edge.
    task automatic checkOutput();
        exp_t e;
        bit   doPush;
        bit   doPop;
        checkVal("in_ready", 32'(bus.in_ready), 32'(!modelHold && (sb.size() < DEPTH)));
        checkVal("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        if (bus.out_valid && (sb.size() != 0)) begin
            checkVal("out_pa", bus.out_pa, sb[0].pa);
            checkVal("out_va", bus.out_va, sb[0].va);
            checkVal("out_mat", 32'(bus.out_mat), 32'(sb[0].mat));
            checkVal("out_is_store", 32'(bus.out_is_store), 32'(sb[0].isStore));
            checkVal("out_size", 32'(bus.out_size), 32'(sb[0].size));
            checkVal("out_exc", 32'(bus.out_exc), 32'(sb[0].exc));
            checkVal("out_ecode", 32'(bus.out_ecode), 32'(sb[0].ecode));
        end
        doPop  = (sb.size() != 0) && bus.out_ready;
        doPush = bus.in_valid && !modelHold && (sb.size() < DEPTH);
        if (flush) begin
            sb.delete();
            modelHold = 1'b0;
        end else begin
            if (doPop) void'(sb.pop_front());
            if (doPush) begin
                e.pa      = bus.tr_pa;
                e.va      = bus.in_va;
                e.mat     = bus.tr_mat;
                e.isStore = bus.in_is_store;
                e.size    = bus.in_size;
                e.ecode   = refEcode(bus.in_va, bus.in_is_store, bus.in_size, bus.tr_page_fault,
                                     bus.tr_page_invalid, bus.tr_page_dirty, bus.tr_plv_fault);
                e.exc     = (e.ecode != 6'h00);
                sb.push_back(e);
                if (e.exc) modelHold = 1'b1;
            end
        end
    endtask

    // flags = {page_fault, page_invalid, page_dirty, plv_fault}
    task automatic applyStimulus(input logic v, input logic st, input logic [1:0] size,
                                 input logic [31:0] va, input logic [31:0] pa,
                                 input logic [1:0] mat, input logic [3:0] flags,
                                 input logic ordy, input logic fl);
        bus.in_valid        = v;
        bus.in_is_store     = st;
        bus.in_size         = size;
        bus.in_va           = va;
        bus.tr_pa           = pa;
        bus.tr_mat          = mat;
        bus.tr_page_fault   = flags[3];
        bus.tr_page_invalid = flags[2];
        bus.tr_page_dirty   = flags[1];
        bus.tr_plv_fault    = flags[0];
        bus.out_ready       = ordy;
        flush               = fl;
        #1;
        checkOutput();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy, input logic fl);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0, 4'b0000, ordy, fl);
    endtask

    task automatic checkResetOutputs();
        checkVal("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("rst_out_exc", 32'(bus.out_exc), 32'd0);
        checkVal("rst_out_ecode", 32'(bus.out_ecode), 32'd0);
        checkVal("rst_out_pa", bus.out_pa, 32'd0);
        checkVal("rst_out_va", bus.out_va, 32'd0);
        checkVal("rst_out_mat", 32'(bus.out_mat), 32'd0);
        checkVal("rst_out_is_store", 32'(bus.out_is_store), 32'd0);
        checkVal("rst_out_size", 32'(bus.out_size), 32'd0);
        checkVal("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        modelHold = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        bus.in_valid = 1'b0; bus.in_is_store = 1'b0; bus.in_size = 2'd0; bus.in_va = 32'h0;
        bus.tr_pa = 32'h0; bus.tr_mat = 2'd0; bus.tr_page_fault = 1'b0;
        bus.tr_page_invalid = 1'b0; bus.tr_page_dirty = 1'b0; bus.tr_plv_fault = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkResetOutputs();

        // Plain load passes through with one cycle latency.
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h1C000104, 32'h00000104, 2'd1, 4'b0000, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Store to a clean page raises PME and blocks input until flush.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h00002000, 32'h00012000, 2'd1, 4'b0010, 1'b0, 1'b0);
        checkVal("pme_ecode", 32'(bus.out_ecode), 32'h04);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h00002004, 32'h00012004, 2'd1, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h00002008, 32'h00012008, 2'd1, 4'b0000, 1'b1, 1'b0);
        checkVal("hold_in_ready", 32'(bus.in_ready), 32'd0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // Dirty flag is ignored for loads.
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h00003002, 32'h00013002, 2'd0, 4'b0010, 1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // All translation faults at once on a load: TLBR wins.
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h00004000, 32'h00014000, 2'd1, 4'b1101, 1'b0, 1'b0);
        checkVal("tlbr_ecode", 32'(bus.out_ecode), 32'h3F);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);

        // Page-invalid store, then plv fault load.
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h00005001, 32'h00015001, 2'd2, 4'b0101, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h00005003, 32'h00015003, 2'd3, 4'b0001, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);

        // Three back-to-back loads while stalled, then drain in order.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd2, 32'h00006000 + 32'(i * 4), 32'h00016000 + 32'(i * 4),
                          2'(i), 4'b0000, 1'b0, 1'b0);
        end
        checkVal("full_in_ready", 32'(bus.in_ready), 32'd0);
        idle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);

        // Flush with a full buffer, a pop and a push in the same cycle discards everything.
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h00007000, 32'h00017000, 2'd1, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h00007004, 32'h00017004, 2'd1, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h00007008, 32'h00017008, 2'd1, 4'b0000, 1'b1, 1'b1);
        checkVal("flush_out_valid", 32'(bus.out_valid), 32'd0);
        idle(1'b1, 1'b0);

        // Misaligned word store with a TLB miss: ALE only when the check is built in.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h00001002, 32'h00011002, 2'd1, 4'b1000, 1'b0, 1'b0);
`ifdef MEM_TRANS_ALE_EN
        checkVal("ale_ecode", 32'(bus.out_ecode), 32'h09);
`else
        checkVal("ale_ecode", 32'(bus.out_ecode), 32'h3F);
`endif
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);

        // Reset mid-operation clears buffered entries and output fields.
        applyStimulus(1'b1, 1'b1, 2'd1, 32'h00008002, 32'h00018002, 2'd3, 4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        modelHold = 1'b0;
        #1;
        checkResetOutputs();

        // Random traffic with occasional faults; flush frees the stage after an exception.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] fl4;
            fl4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom, 2'($urandom),
                          fl4, 1'($urandom_range(0, 3) != 0),
                          (modelHold && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 15) == 0));
        end

        repeat (4) idle(1'b1, 1'b0);
        checkVal("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_trans_stage.md
Name: mem_trans_stage

Overview:
Pipeline stage directly downstream of the data-side address translation logic. Each cycle it takes one load/store request together with the same-cycle translation result (pa, mat, fault flags). It classifies LoongArch memory exceptions, registers the request into a small skid buffer, and presents it to the dcache request interface with a valid/ready handshake. Once an exception is accepted, the stage blocks all further requests until the pipeline is flushed.

Parameters:
DEPTH, 2, number of buffer entries; supported values are 1 and 2.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  discard all buffered entries and leave the exception-hold state
in_valid  input  1  a request is present
in_ready  output  1  stage accepts the request this cycle
in_va  input  32  virtual address
in_is_store  input  1  1 = store, 0 = load
in_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
tr_pa  input  32  translated physical address
tr_mat  input  2  memory access type
tr_page_fault  input  1  TLB miss
tr_page_invalid  input  1  TLB entry V = 0
tr_page_dirty  input  1  TLB entry D = 0 (store needs a dirty page)
tr_plv_fault  input  1  privilege-level violation
out_valid  output  1  head entry is valid
out_ready  input  1  consumer accepts the head entry
out_pa  output  32  physical address
out_va  output  32  virtual address, also used as BADV
out_mat  output  2  memory access type
out_is_store  output  1  store flag
out_size  output  2  access size
out_exc  output  1  head entry carries an exception
out_ecode  output  6  exception code; 0 when out_exc = 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state uses synchronous reset only.
- Reset values:
  - entry count = 0, state = RUN
  - out_valid = 0, out_exc = 0, out_ecode = 0, out_pa = 0, out_va = 0, out_mat = 0, out_is_store = 0, out_size = 0
  - in_ready as defined below; it evaluates to 1 after reset.
- Exception classification, combinational at input, in priority order:
  - TLBR 6'h3F when tr_page_fault
  - otherwise PIS 6'h02 (store) or PIL 6'h01 (load) when tr_page_invalid
  - otherwise PPI 6'h07 when tr_plv_fault
  - otherwise PME 6'h04 when in_is_store && tr_page_dirty
  - otherwise no exception.
- tr_page_dirty is ignored for loads.
- Accept condition: in_valid && in_ready. On accept, the entry {pa, va, mat, is_store, size, exc, ecode} is written at the FIFO tail.
- Latency: an entry accepted in cycle N is visible on the out_* ports in cycle N+1 at the earliest. There is no combinational path from in_* to out_*.
- Output handshake:
  - Pop on out_valid && out_ready.
  - While out_valid = 1 and out_ready = 0, all out_* fields hold stable.
- in_ready:
  - DEPTH = 2: in_ready = (state == RUN) && (count < 2). This uses registered signals only; there is no path from out_ready.
  - DEPTH = 1: in_ready = (state == RUN) && (count == 0 || out_ready).
- A push and a pop in the same cycle leave count unchanged, and FIFO order is preserved.
- State machine:
  - RUN -> HOLD when an entry with exc = 1 is accepted.
  - HOLD -> RUN only on flush.
  - In HOLD, in_ready = 0. Entries already buffered, including the excepting one, still drain normally.
- flush has priority over everything in the same cycle:
  - count <- 0, state <- RUN.
  - Any push or pop in that cycle is discarded.
  - out_valid = 0 in the next cycle.
- reset asserted mid-operation behaves like flush and additionally returns all out_* fields to their reset values.
- out_ecode is forced to 0 whenever out_exc = 0.

Optional Feature:
MEM_TRANS_ALE_EN:
- Defined: an alignment check sits above TLBR in priority.
  - half with va[0] = 1 raises ALE 6'h09
  - word (size 2 or 3) with va[1:0] != 0 raises ALE 6'h09
  - ALE is raised regardless of the translation flags.
- Not defined: no alignment check; the priority chain starts at TLBR.

Test Plan:
1. Load va = 0x1C000104, pa = 0x00000104, mat = 1, no faults, out_ready = 1 -> one cycle later out_valid = 1, out_pa = 0x00000104, out_exc = 0. Stage stays in RUN.
2. Store with tr_page_dirty = 1, other flags 0 -> out_exc = 1, out_ecode = 6'h04. in_ready = 0 from the next cycle until flush; after a flush pulse, in_ready = 1.
3. Simultaneous tr_page_fault = 1, tr_page_invalid = 1, tr_plv_fault = 1 on a load -> out_ecode = 6'h3F.
4. DEPTH = 2, out_ready = 0, three back-to-back valid loads -> first two accepted, in_ready = 0 on the third. Raise out_ready -> entries drain in order, one per cycle, with fields stable while stalled.
5. Buffer holds 2 entries, flush asserted together with out_ready = 1 and in_valid = 1 -> next cycle out_valid = 0, count = 0, nothing from that cycle retained.
6. With MEM_TRANS_ALE_EN defined: word store at va = 0x00001002 with tr_page_fault = 1 -> out_ecode = 6'h09. Without the macro, the same stimulus gives 6'h3F.
